ad_capture_ctrl: RTL

AD_CAPTURE_CTRL -- requirements
Module: ad_capture_ctrl

---
 rtl/ad_cap_pkg.sv | 24 ++
 rtl/ad_trig_det.sv | 47 ++++
 rtl/ad_capture_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ad_cap_pkg.sv
// ad_cap_pkg: shared definitions for the ADC capture controller.
//   AD_DATA_W / AD_ADDR_W : default sample width and capture RAM address width
//   AD_DEPTH              : default capture RAM depth (2^AD_ADDR_W)
//   cap_state_e           : capture controller state encoding
//   is_capture()          : true in the states that write samples to RAM
package ad_cap_pkg;

    localparam int AD_DATA_W = 16;
    localparam int AD_ADDR_W = 10;
    localparam int AD_DEPTH  = 1 << AD_ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StPreFill,
        StWaitTrig,
        StPost,
        StDone
    } cap_state_e;

    function automatic logic is_capture(input cap_state_e st);
        return (st == StPreFill) || (st == StWaitTrig) || (st == StPost);
    endfunction

endpackage

// File: rtl/ad_trig_det.sv
// ad_trig_det: level-crossing edge detector on the valid sample stream.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sample       : current sample (signed)
//   i_vld          : current sample is being captured; updates the previous-sample register
//   i_wait         : controller is waiting for a trigger; outside it qualification is dropped
//   i_level        : signed threshold
//   i_fall         : 0 = rising crossing, 1 = falling crossing
//   o_trig_hit     : combinational hit on the current sample
module ad_trig_det
    import ad_cap_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic                     i_vld,
    input  logic                     i_wait,
    input  logic signed [DATA_W-1:0] i_level,
    input  logic                     i_fall,
    output logic                     o_trig_hit
);

    logic signed [DATA_W-1:0] r_prev;
    logic                     r_qual;
    logic                     w_rise;
    logic                     w_fall;

    // r_qual only becomes set by a valid sample seen while waiting, so the first
    // sample after entering the wait state can never fire on a stale prev.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_qual <= 1'b0;
        end else begin
            if (i_vld) begin
                r_prev <= i_sample;
            end
            r_qual <= i_wait ? (r_qual | i_vld) : 1'b0;
        end
    end

    assign w_rise     = (r_prev < i_level) && (i_sample >= i_level);
    assign w_fall     = (r_prev > i_level) && (i_sample <= i_level);
    assign o_trig_hit = i_wait && i_vld && r_qual && (i_fall ? w_fall : w_rise);

endmodule

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: pre/post-trigger ADC capture into a circular RAM.
//   clkin_bufr, io_reset_n        : clock, asynchronous active-low reset (release synchronised)
//   ad_din, ad_vld                : signed sample stream and qualifier
//   arm, abort, force_trig        : start pulse, cancel, software trigger
//   trig_level, trig_fall         : trigger threshold and edge select
//   pre_cnt, post_cnt             : pre-trigger and post-trigger (incl. trigger) sample counts
//   wr_en, wr_addr, wr_data       : capture RAM write port (same-cycle with ad_vld)
//   busy, done, trig_addr, cfg_err: status
//   done_ack                      : host readout finished, returns DONE to IDLE
module ad_capture_ctrl
    import ad_cap_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W,
    parameter int ADDR_W = AD_ADDR_W
) (
    input  logic                     clkin_bufr,
    input  logic                     io_reset_n,
    input  logic signed [DATA_W-1:0] ad_din,
    input  logic                     ad_vld,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     force_trig,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     trig_fall,
    input  logic [ADDR_W-1:0]        pre_cnt,
    input  logic [ADDR_W:0]          post_cnt,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic                     cfg_err,
    input  logic                     done_ack
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W+1:0] L_DEPTH   = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  L_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] L_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]               r_rst_sync;
    logic                     w_run;
    cap_state_e               r_state;
    logic [ADDR_W-1:0]        r_ptr;
    logic [ADDR_W-1:0]        r_trig_addr;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_post;
    logic signed [DATA_W-1:0] r_level;
    logic                     r_fall;
    logic                     r_cfg_err;
    logic                     r_force_pend;

    logic                     w_wr;
    logic                     w_in_wait;
    logic                     w_trig_hit;
    logic                     w_fire;
    logic [ADDR_W+1:0]        w_sum;
    logic                     w_cfg_bad;

    // Assertion is immediate; the FSM only starts moving once the release has
    // passed through both flops.
    always_ff @(posedge clkin_bufr or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_run = r_rst_sync[1];

    assign w_wr      = is_capture(r_state) && ad_vld && !abort;
    assign w_in_wait = (r_state == StWaitTrig);
    assign w_fire    = w_wr && w_in_wait && (w_trig_hit || force_trig || r_force_pend);
    assign w_sum     = {2'b00, pre_cnt} + {1'b0, post_cnt};
    assign w_cfg_bad = (post_cnt == '0) || (w_sum > L_DEPTH);

    ad_trig_det #(
        .DATA_W(DATA_W)
    ) u_trig_det (
        .i_clk     (clkin_bufr),
        .i_rst_n   (io_reset_n),
        .i_sample  (ad_din),
        .i_vld     (w_wr),
        .i_wait    (w_in_wait),
        .i_level   (r_level),
        .i_fall    (r_fall),
        .o_trig_hit(w_trig_hit)
    );

    always_ff @(posedge clkin_bufr or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_trig_addr  <= '0;
            r_cnt        <= '0;
            r_post       <= '0;
            r_level      <= '0;
            r_fall       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_force_pend <= 1'b0;
        end else if (w_run) begin
            if (abort) begin
                r_state      <= StIdle;
                r_force_pend <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (arm) begin
                            if (w_cfg_bad) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_level      <= trig_level;
                                r_fall       <= trig_fall;
                                r_post       <= post_cnt;
                                r_cnt        <= {1'b0, pre_cnt};
                                r_ptr        <= '0;
                                r_cfg_err    <= 1'b0;
                                r_force_pend <= 1'b0;
                                r_state      <= (pre_cnt == '0) ? StWaitTrig : StPreFill;
                            end
                        end
                    end
                    StPreFill: begin
                        if (ad_vld) begin
                            r_ptr <= r_ptr + L_PTR_ONE;
                            r_cnt <= r_cnt - L_CNT_ONE;
                            if (r_cnt == L_CNT_ONE) begin
                                r_state <= StWaitTrig;
                            end
                        end
                    end
                    StWaitTrig: begin
                        if (ad_vld) begin
                            r_ptr <= r_ptr + L_PTR_ONE;
                            if (w_fire) begin
                                // Trigger sample is post sample 1.
                                r_trig_addr  <= r_ptr;
                                r_force_pend <= 1'b0;
                                r_cnt        <= r_post - L_CNT_ONE;
                                r_state      <= (r_post == L_CNT_ONE) ? StDone : StPost;
                            end
                        end else if (force_trig) begin
                            r_force_pend <= 1'b1;
                        end
                    end
                    StPost: begin
                        if (ad_vld) begin
                            r_ptr <= r_ptr + L_PTR_ONE;
                            r_cnt <= r_cnt - L_CNT_ONE;
                            if (r_cnt == L_CNT_ONE) begin
                                r_state <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        if (done_ack) begin
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign wr_en     = w_wr;
    assign wr_addr   = r_ptr;
    assign wr_data   = w_wr ? ad_din : '0;
    assign busy      = (r_state != StIdle) && (r_state != StDone);
    assign done      = (r_state == StDone);
    assign trig_addr = r_trig_addr;
    assign cfg_err   = r_cfg_err;

endmodule
